// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the pipelined handshake multiplier.
//   DEF_*      default configuration used by pipe_mult_hs and mult_hs_stage
//   stage_t    per-stage register layout at the default configuration
//   mag_of     magnitude of a zero-extended operand (caller truncates to WIDTH)
//   cfg_ok     elaboration-time legality of a WIDTH/STAGES pair
package mult_pkg;

  localparam int unsigned DEF_WIDTH  = 64;
  localparam int unsigned DEF_STAGES = 8;
  localparam int unsigned DEF_TAG_W  = 4;

  // Upper bound on operand width handled by mag_of.
  localparam int unsigned MAG_MAX_W = 256;

  typedef struct packed {
    logic                     valid;
    logic [2*DEF_WIDTH-1:0]   sum;
    logic [DEF_WIDTH-1:0]     mplier;
    logic [2*DEF_WIDTH-1:0]   mcand;
    logic                     neg;
    logic [DEF_TAG_W-1:0]     tag;
  } stage_t;

  // Negation is done at MAG_MAX_W bits; the low WIDTH bits equal the WIDTH-bit
  // two's-complement negation, so -2^(WIDTH-1) maps to 2^(WIDTH-1) as wanted.
  function automatic logic [MAG_MAX_W-1:0] mag_of(input logic [MAG_MAX_W-1:0] val,
                                                  input logic                 neg);
    return neg ? (MAG_MAX_W'(0) - val) : val;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0) &&
           (width < MAG_MAX_W);
  endfunction

endpackage

// File: rtl/mult_hs_stage.sv
// mult_hs_stage: one pipeline stage of pipe_mult_hs.
//   clock, reset  rising-edge clock, synchronous active-high reset (clears all)
//   flush         clears the valid bit only
//   en            load d_in-derived state this cycle, otherwise hold
//   d_in          state arriving from the previous stage (or the front end)
//   q_out         registered state of this stage
// Adds (low SHIFT multiplier bits) * shifted multiplicand to the running sum,
// then shifts the multiplier right and the multiplicand left by SHIFT.
// The LAST stage applies the sign correction before registering.
module mult_hs_stage
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHIFT   = DEF_WIDTH / DEF_STAGES,
  parameter bit          LAST    = 1'b0,
  parameter type         stage_t = mult_pkg::stage_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   flush,
  input  logic   en,
  input  stage_t d_in,
  output stage_t q_out
);

  stage_t             stage_d;
  stage_t             stage_q;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc;

  always_comb begin
    pp  = d_in.mcand * {{(2*WIDTH-SHIFT){1'b0}}, d_in.mplier[SHIFT-1:0]};
    acc = d_in.sum + pp;

    stage_d        = d_in;
    stage_d.sum    = (LAST && d_in.neg) ? ((2*WIDTH)'(0) - acc) : acc;
    stage_d.mplier = d_in.mplier >> SHIFT;
    stage_d.mcand  = d_in.mcand << SHIFT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      if (en) begin
        stage_q <= stage_d;
      end
      if (flush) begin
        stage_q.valid <= 1'b0;
      end
    end
  end

  assign q_out = stage_q;

endmodule

// File: rtl/pipe_mult_hs.sv
// pipe_mult_hs: fully pipelined WIDTH x WIDTH multiplier, full 2*WIDTH product,
// valid/ready on both sides, per-operation signed/unsigned mode and tag.
//   clock, reset          rising-edge clock, synchronous active-high reset
//   flush                 kill all in-flight operations (and any same-cycle accept)
//   in_valid / in_ready   issue handshake
//   is_signed             1 = two's-complement operands
//   mcand, mplier, in_tag operands and opaque tag
//   out_valid / out_ready result handshake
//   product, out_tag      result and its tag; held while stalled
// The last stage register is the output register, so STAGES operations can
// be in flight. Bubbles collapse: a stage loads whenever it is empty or the
// stage after it moves on.
module pipe_mult_hs
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned SHIFT = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_mult_hs: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  typedef struct packed {
    logic               valid;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic               neg;
    logic [TAG_W-1:0]   tag;
  } stg_t;

  stg_t              stg_in [STAGES];
  stg_t              stg_q  [STAGES];
  stg_t              front;
  logic [STAGES-1:0] stg_valid;
  logic [STAGES:0]   adv;
  logic              mcand_neg;
  logic              mplier_neg;
  logic [WIDTH-1:0]  mcand_mag;
  logic [WIDTH-1:0]  mplier_mag;

  // Ready chain walks from the output back to the input inside one process.
  always_comb begin
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = !stg_valid[i] || adv[i+1];
    end
  end

  assign in_ready = adv[0];

  // Operands enter as magnitudes; the sign is re-applied in the last stage.
  always_comb begin
    mcand_neg  = is_signed & mcand[WIDTH-1];
    mplier_neg = is_signed & mplier[WIDTH-1];
    mcand_mag  = WIDTH'(mag_of(MAG_MAX_W'(mcand), mcand_neg));
    mplier_mag = WIDTH'(mag_of(MAG_MAX_W'(mplier), mplier_neg));

    front        = '0;
    front.valid  = in_valid & in_ready;
    front.sum    = '0;
    front.mplier = mplier_mag;
    front.mcand  = {{WIDTH{1'b0}}, mcand_mag};
    front.neg    = mcand_neg ^ mplier_neg;
    front.tag    = in_tag;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign stg_in[i] = front;
    end else begin : g_rest
      assign stg_in[i] = stg_q[i-1];
    end

    mult_hs_stage #(
      .WIDTH   (WIDTH),
      .SHIFT   (SHIFT),
      .LAST    (i == STAGES - 1),
      .stage_t (stg_t)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .en    (adv[i]),
      .d_in  (stg_in[i]),
      .q_out (stg_q[i])
    );

    assign stg_valid[i] = stg_q[i].valid;
  end

  assign out_valid = stg_q[STAGES-1].valid;
  assign product   = stg_q[STAGES-1].sum;
  assign out_tag   = stg_q[STAGES-1].tag;

  // Fully consumed multiplier/multiplicand leave the last stage unused.
  logic unused_tail;
  assign unused_tail = ^{stg_q[STAGES-1].mplier, stg_q[STAGES-1].mcand,
                         stg_q[STAGES-1].neg};

endmodule

// File: tb/tb_pipe_mult_hs.sv
module tb_pipe_mult_hs;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned STAGES = 8;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned PW     = 2 * WIDTH;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    product;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [PW-1:0]    prod;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  pipe_mult_hs #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .mcand     (mcand),
    .mplier    (mplier),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .out_tag   (out_tag)
  );

  // Reference: sign/zero extend to PW bits and multiply modulo 2^PW.
  function automatic logic [PW-1:0] ref_mult(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             s);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb = s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return {{(WIDTH-1){1'b0}}, 1'b1};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [TAG_W-1:0] t);
    mcand     = a;
    mplier    = b;
    is_signed = s;
    in_tag    = t;
  endtask

  // One clock: scoreboard step at the falling edge, then move to just after
  // the next rising edge where stimulus is driven and outputs are sampled.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got product=%h tag=%h, required no output",
                   product, out_tag);
        end else begin
          e = sb_q.pop_front();
          if (product !== e.prod || out_tag !== e.tag) begin
            errors++;
            $display("FAIL sb_result: got product=%h tag=%h, required product=%h tag=%h",
                     product, out_tag, e.prod, e.tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.prod = ref_mult(mcand, mplier, is_signed);
        e.tag  = in_tag;
        sb_q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (product !== '0) begin
      errors++; $display("FAIL reset_product: got %h, required 0", product);
    end
    checks++;
    if (out_tag !== '0) begin
      errors++; $display("FAIL reset_out_tag: got %h, required 0", out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int cnt;
    out_ready = 1'b1;
    set_op(64'd3, 64'd5, 1'b0, 4'hA);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 1;
    while (out_valid !== 1'b1 && cnt < 4 * STAGES) begin
      tick();
      cnt++;
    end
    checks++;
    if (out_valid !== 1'b1 || cnt != STAGES) begin
      errors++; $display("FAIL basic_latency: got %0d cycles (valid=%b), required %0d",
                         cnt, out_valid, STAGES);
    end
    checks++;
    if (product !== 128'd15) begin
      errors++; $display("FAIL basic_product: got %h, required %h", product, 128'd15);
    end
    checks++;
    if (out_tag !== 4'hA) begin
      errors++; $display("FAIL basic_tag: got %h, required a", out_tag);
    end
    repeat (2) tick();
  endtask

  task automatic test_signed();
    logic [WIDTH-1:0] a [4];
    logic [WIDTH-1:0] b [4];
    logic             s [4];
    logic [PW-1:0]    e [4];
    int               n;
    a[0] = '1;                      b[0] = '1;                      s[0] = 1'b1;
    e[0] = 128'd1;
    a[1] = 64'hFFFF_FFFF_FFFF_FFF9; b[1] = 64'd6;                   s[1] = 1'b1;
    e[1] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6;
    a[2] = 64'h8000_0000_0000_0000; b[2] = 64'h8000_0000_0000_0000; s[2] = 1'b1;
    e[2] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    a[3] = '1;                      b[3] = '1;                      s[3] = 1'b0;
    e[3] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(a[i], b[i], s[i], TAG_W'(i + 1));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 4 * STAGES && n < 4; c++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (product !== e[n] || out_tag !== TAG_W'(n + 1)) begin
          errors++; $display("FAIL signed_case%0d: got product=%h tag=%h, required product=%h tag=%h",
                             n, product, out_tag, e[n], TAG_W'(n + 1));
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL signed_count: got %0d results, required 4", n);
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    int   accepts;
    out_ready = 1'b0;
    accepts   = 0;
    for (int c = 0; c < 3 * STAGES; c++) begin
      set_op(rand_operand(), rand_operand(), c[0], TAG_W'(accepts));
      in_valid = 1'b1;
      if (in_ready === 1'b1) begin
        e.prod = ref_mult(mcand, mplier, is_signed);
        e.tag  = in_tag;
        q.push_back(e);
        accepts++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (accepts != STAGES) begin
      errors++; $display("FAIL bp_accepts: got %0d, required %0d", accepts, STAGES);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready_full: got %b, required 0", in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      if (q.size() > 0) e = q.pop_front();
      else begin e.prod = '0; e.tag = '0; end
      checks++;
      if (out_valid !== 1'b1 || product !== e.prod || out_tag !== e.tag) begin
        errors++; $display("FAIL bp_drain%0d: got valid=%b product=%h tag=%h, required valid=1 product=%h tag=%h",
                           k, out_valid, product, out_tag, e.prod, e.tag);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after_drain: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_random();
    int issued;
    int cyc;
    issued = 0;
    cyc    = 0;
    while (issued < 1000 && cyc < 20000) begin
      set_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
             TAG_W'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) issued++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((sb_q.size() != 0 || out_valid === 1'b1) && cyc < 4 * STAGES) begin
      tick();
      cyc++;
    end
    checks++;
    if (issued != 1000) begin
      errors++; $display("FAIL rand_issued: got %0d, required 1000", issued);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: got %0d outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    int stale;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(rand_operand(), rand_operand(), 1'b1, TAG_W'(i + 3));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || product !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_inflight: got valid=%b product=%h tag=%h in_ready=%b, required 0/0/0/1",
                         out_valid, product, out_tag, in_ready);
    end
    reset = 1'b0;
    stale = 0;
    for (int c = 0; c < 2 * STAGES + 4; c++) begin
      if (out_valid !== 1'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL rst_stale: got %0d valid cycles, required 0", stale);
    end
  endtask

  task automatic test_flush();
    int               stale;
    int               cnt;
    logic [PW-1:0]    exp_p;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(rand_operand(), rand_operand(), 1'b0, TAG_W'(i + 8));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_pre_stall: got out_valid=%b, required 1", out_valid);
    end
    set_op(64'd11, 64'd13, 1'b0, 4'hF);
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_clear: got valid=%b in_ready=%b, required 0/1",
                         out_valid, in_ready);
    end
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < STAGES + 4; c++) begin
      if (out_valid !== 1'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL flush_stale: got %0d valid cycles, required 0", stale);
    end
    set_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd9, 1'b1, 4'h5);
    exp_p = ref_mult(mcand, mplier, is_signed);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 1;
    while (out_valid !== 1'b1 && cnt < 4 * STAGES) begin
      tick();
      cnt++;
    end
    checks++;
    if (out_valid !== 1'b1 || cnt != STAGES || product !== exp_p || out_tag !== 4'h5) begin
      errors++; $display("FAIL flush_next_op: got valid=%b cycles=%0d product=%h tag=%h, required 1/%0d/%h/5",
                         out_valid, cnt, product, out_tag, STAGES, exp_p);
    end
    repeat (2) tick();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_op('0, '0, 1'b0, '0);
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
